// File: rtl/ext_pkg.sv
// Shared constants for the ext_pipe immediate extender: mode selects and
// pipeline state encodings. Optional build macro: EXT_PIPE_PERF_EN.
package ext_pkg;

  // Extension mode selects, as driven on i_mode
  localparam logic [1:0] EXT_SEXT  = 2'b00;
  localparam logic [1:0] EXT_ZEXT  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;
  localparam logic [1:0] EXT_SHL   = 2'b11;

  // Pipeline occupancy states: no beat, output register only, output + skid
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL1 = 2'd1;
  localparam logic [1:0] FULL2 = 2'd2;

endpackage

// File: rtl/ext_core.sv
// Combinational extension core for ext_pipe. Selects one of four ways to
// widen an immediate field: sign extend, zero extend, upper placement (LUI),
// or sign extend followed by a left shift (branch offsets).
module ext_core
  import ext_pkg::*;
#(
  parameter int REG_IN_SIZE  = 16,
  parameter int REG_OUT_SIZE = 32,
  parameter int BR_SHIFT     = 2
) (
  input  logic [REG_IN_SIZE-1:0]  reg_i,
  input  logic [1:0]              mode_i,
  output logic [REG_OUT_SIZE-1:0] reg_o
);

  localparam int PAD = REG_OUT_SIZE - REG_IN_SIZE;

  logic [REG_OUT_SIZE-1:0] sextVal;
  logic [REG_OUT_SIZE-1:0] zextVal;
  logic [REG_OUT_SIZE-1:0] upperVal;
  logic [REG_OUT_SIZE-1:0] shlVal;

  assign sextVal  = {{PAD{reg_i[REG_IN_SIZE-1]}}, reg_i};
  assign zextVal  = {{PAD{1'b0}}, reg_i};
  assign upperVal = {reg_i, {PAD{1'b0}}};
  assign shlVal   = sextVal << BR_SHIFT;

  // Mode mux: pick the extended form requested by the decoder
  always_comb begin
    reg_o = sextVal;
    case (mode_i)
      EXT_SEXT:  reg_o = sextVal;
      EXT_ZEXT:  reg_o = zextVal;
      EXT_UPPER: reg_o = upperVal;
      EXT_SHL:   reg_o = shlVal;
      default:   reg_o = sextVal;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered multi-mode immediate extender between decode and execute.
// The field is extended on the way in, then held in an output register
// backed by a skid register so that o_ready is always a flop output and
// execute-stage stalls never create a combinational ready path.
// Optional build macro: EXT_PIPE_PERF_EN adds o_stall_cnt, a saturating
// count of cycles where a beat is offered but not taken downstream.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int REG_IN_SIZE  = 16,
  parameter int REG_OUT_SIZE = 32,
  parameter int BR_SHIFT     = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [REG_IN_SIZE-1:0]  i_reg,
  input  logic [1:0]              i_mode,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [REG_OUT_SIZE-1:0] o_reg
`ifdef EXT_PIPE_PERF_EN
  ,
  output logic [15:0]             o_stall_cnt
`endif
);

  logic [REG_OUT_SIZE-1:0] extVal;

  logic [1:0]              state_q,    state_d;
  logic [REG_OUT_SIZE-1:0] outReg_q,   outReg_d;
  logic [REG_OUT_SIZE-1:0] skidReg_q,  skidReg_d;
  logic                    outValid_q, outValid_d;
  logic                    inReady_q,  inReady_d;

  logic inXfer;
  logic outXfer;

  ext_core #(
    .REG_IN_SIZE (REG_IN_SIZE),
    .REG_OUT_SIZE(REG_OUT_SIZE),
    .BR_SHIFT    (BR_SHIFT)
  ) u_core (
    .reg_i (i_reg),
    .mode_i(i_mode),
    .reg_o (extVal)
  );

  assign inXfer  = i_valid && inReady_q;
  assign outXfer = outValid_q && i_ready;

  assign o_ready = inReady_q;
  assign o_valid = outValid_q;
  assign o_reg   = outReg_q;

  // Next-state logic: route the new beat to the output or skid register and
  // precompute the flags so valid/ready come straight from flops
  always_comb begin
    state_d   = state_q;
    outReg_d  = outReg_q;
    skidReg_d = skidReg_q;
    case (state_q)
      EMPTY: begin
        if (inXfer) begin
          outReg_d = extVal;
          state_d  = FULL1;
        end
      end
      FULL1: begin
        if (inXfer && outXfer) begin
          outReg_d = extVal;
        end else if (outXfer) begin
          state_d = EMPTY;
        end else if (inXfer) begin
          skidReg_d = extVal;
          state_d   = FULL2;
        end
      end
      FULL2: begin
        if (outXfer) begin
          outReg_d = skidReg_q;
          state_d  = FULL1;
        end
      end
      default: state_d = EMPTY;
    endcase
    outValid_d = (state_d != EMPTY);
    inReady_d  = (state_d != FULL2);
  end

  // Pipeline registers; a low reset drops any in-flight or skid beat
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= EMPTY;
      outReg_q   <= '0;
      skidReg_q  <= '0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      outReg_q   <= outReg_d;
      skidReg_q  <= skidReg_d;
      outValid_q <= outValid_d;
      inReady_q  <= inReady_d;
    end
  end

`ifdef EXT_PIPE_PERF_EN
  logic [15:0] stallCnt_q;

  // Stall counter: cycles where a beat waits on downstream, sticks at all-ones
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      stallCnt_q <= '0;
    end else if (outValid_q && !i_ready && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_q <= stallCnt_q + 16'd1;
    end
  end

  assign o_stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed vectors from a table,
// hand-written backpressure / streaming / reset sequences, then random
// traffic, all tracked by a queue-based reference model of a 2-deep FIFO.
module tb_ext_pipe;

  logic        clk;
  logic        iReset;
  logic        iValid;
  logic        oReady;
  logic [15:0] iReg;
  logic [1:0]  iMode;
  logic        oValid;
  logic        iReady;
  logic [31:0] oReg;
`ifdef EXT_PIPE_PERF_EN
  logic [15:0] oStallCnt;
`endif

  int assertCnt = 0;
  int failCnt   = 0;

  logic [31:0] modelQ[$];
  logic [31:0] lastOut;
  int unsigned stallModel;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [15:0] din;
    logic [31:0] expOut;
  } vec_t;

  vec_t vecs[8];

  ext_pipe #(
    .REG_IN_SIZE (16),
    .REG_OUT_SIZE(32),
    .BR_SHIFT    (2)
  ) dut (
    .i_clk  (clk),
    .i_reset(iReset),
    .i_valid(iValid),
    .o_ready(oReady),
    .i_reg  (iReg),
    .i_mode (iMode),
    .o_valid(oValid),
    .i_ready(iReady),
    .o_reg  (oReg)
`ifdef EXT_PIPE_PERF_EN
    ,
    .o_stall_cnt(oStallCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extension computed with plain arithmetic on the field value
  function automatic logic [31:0] refExt(input logic [1:0] mode, input logic [15:0] din);
    logic [31:0] sx;
    sx = (din >= 16'h8000) ? (32'(din) + 32'hFFFF_0000) : 32'(din);
    case (mode)
      2'd0:    return sx;
      2'd1:    return 32'(din);
      2'd2:    return 32'(din) * 32'h0001_0000;
      default: return sx * 32'd4;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCnt++;
    if (actual !== expected) begin
      failCnt++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check outputs against the
  // model, then advance the model by what happens at the next rising edge
  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [15:0] d,
                               input logic rdy, input logic rst);
    logic inX;
    logic outX;
    @(negedge clk);
    iValid = v;
    iMode  = m;
    iReg   = d;
    iReady = rdy;
    iReset = rst;
    #1;
    checkOutput("o_valid", 32'(oValid), 32'(modelQ.size() > 0));
    checkOutput("o_ready", 32'(oReady), 32'(modelQ.size() < 2));
    checkOutput("o_reg", oReg, (modelQ.size() > 0) ? modelQ[0] : lastOut);
`ifdef EXT_PIPE_PERF_EN
    checkOutput("o_stall_cnt", 32'(oStallCnt), stallModel);
`endif
    if (!rst) begin
      modelQ.delete();
      lastOut    = '0;
      stallModel = 0;
    end else begin
      inX  = v && (modelQ.size() < 2);
      outX = (modelQ.size() > 0) && rdy;
      if ((modelQ.size() > 0) && !rdy && (stallModel < 32'hFFFF)) stallModel++;
      if (outX) lastOut = modelQ.pop_front();
      if (inX) modelQ.push_back(refExt(m, d));
    end
  endtask

  // Watchdog so a broken build can never hang the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"sext_5555",  2'd0, 16'h5555, 32'h0000_5555};
    vecs[1] = '{"sext_cafd",  2'd0, 16'hCAFD, 32'hFFFF_CAFD};
    vecs[2] = '{"zext_cafd",  2'd1, 16'hCAFD, 32'h0000_CAFD};
    vecs[3] = '{"upper_1234", 2'd2, 16'h1234, 32'h1234_0000};
    vecs[4] = '{"shl_ffff",   2'd3, 16'hFFFF, 32'hFFFF_FFFC};
    vecs[5] = '{"shl_4000",   2'd3, 16'h4000, 32'h0001_0000};
    vecs[6] = '{"shl_8001",   2'd3, 16'h8001, 32'hFFFE_0004};
    vecs[7] = '{"zext_ffff",  2'd1, 16'hFFFF, 32'h0000_FFFF};

    iReset = 1'b0;
    iValid = 1'b0;
    iReady = 1'b0;
    iMode  = 2'd0;
    iReg   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_o_valid", 32'(oValid), 32'd0);
    checkOutput("reset_o_ready", 32'(oReady), 32'd1);
    checkOutput("reset_o_reg", oReg, 32'd0);
`ifdef EXT_PIPE_PERF_EN
    checkOutput("reset_stall", 32'(oStallCnt), 32'd0);
`endif
    modelQ.delete();
    lastOut    = '0;
    stallModel = 0;

    // Directed mode vectors, one per cycle, latency 1
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].mode, vecs[i].din, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, "_valid"}, 32'(oValid), 32'd1);
      checkOutput(vecs[i].name, oReg, vecs[i].expOut);
    end
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b1);

    // Backpressure: two beats fill output and skid, then drain in order
    applyStimulus(1'b1, 2'd0, 16'h0001, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'd0, 16'h0002, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("bp_ready_low", 32'(oReady), 32'd0);
    checkOutput("bp_hold_a", oReg, 32'd1);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("bp_second_b", oReg, 32'd2);
    checkOutput("bp_ready_back", 32'(oReady), 32'd1);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b1);

    // Streaming: back-to-back beats with downstream always ready
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'(i % 4), 16'(16'h1111 * (i + 1)), 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b1);

    // Reset while both registers are occupied
    applyStimulus(1'b1, 2'd1, 16'hAAAA, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'd1, 16'hBBBB, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_full2_valid", 32'(oValid), 32'd0);
    checkOutput("rst_full2_ready", 32'(oReady), 32'd1);
    checkOutput("rst_full2_reg", oReg, 32'd0);
    repeat (3) applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b1);

`ifdef EXT_PIPE_PERF_EN
    // Stall counter: one beat held for five cycles against a stalled sink
    applyStimulus(1'b1, 2'd0, 16'h0007, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("stall_five", 32'(oStallCnt), 32'd5);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("stall_reset", 32'(oStallCnt), 32'd0);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b1);
`endif

    // Random traffic against the reference model, with rare resets
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)),
                    16'($urandom),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 59) != 0));
    end
    repeat (3) applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Registered, multi-mode immediate extender; parametrised successor of the combinational sign extender.
- Sits between decode and execute in the MIPS datapath.
- Extends an REG_IN_SIZE-bit field to REG_OUT_SIZE bits in one of four modes.
- Valid/ready handshake on both sides; a 2-entry skid buffer absorbs execute-stage stalls without combinational ready paths.

Parameters:
REG_IN_SIZE, 16, width of input field
REG_OUT_SIZE, 32, width of extended result; must be > REG_IN_SIZE
BR_SHIFT, 2, left-shift amount applied in mode SHL (branch offsets)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-low reset
i_valid  in  1  input beat valid
o_ready  out  1  block can accept a beat
i_reg  in  REG_IN_SIZE  field to extend
i_mode  in  2  00 SEXT, 01 ZEXT, 10 UPPER, 11 SHL
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts beat
o_reg  out  REG_OUT_SIZE  extended result

Behaviour:
- Reset: i_clk and i_reset are the only clock and reset. Reset is synchronous and active-low: i_reset sampled low at a rising edge clears all state.
  - After reset: o_valid=0, o_reg=0, o_ready=1, skid empty, state EMPTY.
- Modes (combinational core, registered result):
  - SEXT: replicate i_reg MSB into the upper bits.
  - ZEXT: upper bits 0.
  - UPPER: i_reg placed in bits [OUT-1 : OUT-IN], low bits 0 (LUI).
  - SHL: SEXT result shifted left by BR_SHIFT, bits shifted out discarded, zero fill.
- Handshake: transfer in when i_valid && o_ready; transfer out when o_valid && i_ready. Input values are captured only on input transfer; i_reg/i_mode are don't-care otherwise.
- Latency: 1 cycle. A beat accepted at edge N is presented on o_reg after edge N.
- States:
  - EMPTY: o_valid=0, o_ready=1. Input transfer -> FULL1.
  - FULL1: output register holds a beat, o_ready=1.
    - in && out: output reg reloads, stays FULL1.
    - out only: -> EMPTY.
    - in only: beat goes to skid reg -> FULL2.
    - neither: hold.
  - FULL2: o_ready=0 (registered, derived from skid valid only).
    - out: skid moves to output reg -> FULL1.
    - otherwise hold.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- o_reg holds its last value when o_valid=0.
- Reset mid-operation: any in-flight or skid beat is discarded; next cycle is EMPTY.
- Throughput: 1 beat/cycle with i_ready held high.

Optional Feature:
- Macro EXT_PIPE_PERF_EN.
  - Defined: adds port o_stall_cnt out 16, a saturating counter of cycles with o_valid=1 && i_ready=0. Resets to 0; holds at 16'hFFFF when saturated.
  - Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package ext_pkg: mode localparams EXT_SEXT=2'b00, EXT_ZEXT=2'b01, EXT_UPPER=2'b10, EXT_SHL=2'b11; state encodings EMPTY/FULL1/FULL2.
- One sub-module, ext_core: purely combinational mode mux plus extension, parametrised by REG_IN_SIZE, REG_OUT_SIZE, BR_SHIFT.
- ext_pipe instantiates ext_core once, on the input side, before the registers.

Test Plan:
- SEXT 16'h5555, i_ready=1 -> next cycle o_valid=1, o_reg=32'h00005555. Then SEXT 16'hCAFD -> 32'hFFFFCAFD.
- ZEXT 16'hCAFD -> 32'h0000CAFD. UPPER 16'h1234 -> 32'h12340000. SHL 16'hFFFF -> 32'hFFFFFFFC. SHL 16'h4000 -> 32'h00010000.
- Backpressure: i_ready=0, send A=16'h0001 then B=16'h0002 (SEXT) -> o_ready low after B, o_reg=1 held. Release i_ready -> outputs 1 then 2 in consecutive cycles; o_ready returns high.
- Streaming: 8 back-to-back beats with i_ready=1 -> 8 outputs, 1 per cycle, in order, latency 1.
- Reset in FULL2 (i_reset=0 one edge) -> o_valid=0, o_ready=1, o_reg=0; no stale beat emitted after release.
- EXT_PIPE_PERF_EN defined: hold i_ready=0 for 5 cycles with o_valid=1 -> o_stall_cnt=5. Reset -> 0.
